// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by fetch_unit and pc_next.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: sequential step or word-aligned branch target.
// Purely combinational, modulo 2^WIDTH.
module pc_next
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  input  logic             pc_src,
  output logic [WIDTH-1:0] next_pc
);

  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] tgt_pc;

  assign seq_pc = pc + WIDTH'(PC_STEP);
  assign sum    = pc + imm;
  assign tgt_pc = {sum[WIDTH-1:2], 2'b00};

  assign next_pc = pc_src ? tgt_pc : seq_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, imem request FSM, instr hold.
// All outputs come straight from flops; no input reaches an output.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PCsrc,
  input  logic [WIDTH-1:0] ImmOp,
  input  logic             instr_ack,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [WIDTH-1:0] PC,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata
);

  fetch_state_e     state;
  logic [WIDTH-1:0] pc_nx;

  pc_next #(
    .WIDTH(WIDTH)
  ) u_pc_next (
    .pc     (PC),
    .imm    (ImmOp),
    .pc_src (PCsrc),
    .next_pc(pc_nx)
  );

  assign imem_addr = PC;

  // req/valid are registered alongside state so they drop on reset at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      PC          <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            state       <= VALID;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        VALID: begin
          if (instr_ack) begin
            PC          <= pc_nx;
            state       <= FETCH;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random
// handshakes against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCsrc = 1'b0;
  logic [31:0] ImmOp = '0;
  logic        instr_ack = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] PC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] salt = 32'h5A5A_0F0F;

  int total = 0;
  int bad = 0;

  // model of what the stage should be showing
  logic        m_idle;
  logic        m_req;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  fetch_unit #(
    .WIDTH   (32),
    .RESET_PC(32'h0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PCsrc      (PCsrc),
    .ImmOp      (ImmOp),
    .instr_ack  (instr_ack),
    .instr      (instr),
    .instr_valid(instr_valid),
    .PC         (PC),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(
    input logic [31:0] a,
    input logic [31:0] s
  );
    return {a[15:0], a[31:16]} ^ s;
  endfunction

  always_comb imem_rdata = mem_word(imem_addr, salt);

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idle  = 1'b1;
    m_req   = 1'b0;
    m_valid = 1'b0;
    m_pc    = 32'h0;
    m_instr = 32'h0000_0013;
  endtask

  task automatic check_all();
    chk("req", {31'b0, imem_req}, {31'b0, m_req});
    chk("valid", {31'b0, instr_valid}, {31'b0, m_valid});
    chk("pc", PC, m_pc);
    chk("addr", imem_addr, m_pc);
    chk("instr", instr, m_instr);
  endtask

  // apply the effect of the coming edge to the model, then compare
  task automatic step();
    if (m_idle) begin
      m_idle = 1'b0;
      m_req  = 1'b1;
    end else if (m_req) begin
      if (imem_ready) begin
        m_instr = mem_word(m_pc, salt);
        m_req   = 1'b0;
        m_valid = 1'b1;
      end
    end else if (m_valid && instr_ack) begin
      if (PCsrc) m_pc = (m_pc + ImmOp) & 32'hFFFF_FFFC;
      else       m_pc = m_pc + 32'd4;
      m_valid = 1'b0;
      m_req   = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // fetch with zero-wait memory, then consume with the given branch choice
  task automatic go(input logic src, input logic [31:0] imm);
    int n;
    n = 0;
    imem_ready = 1'b1;
    instr_ack  = 1'b0;
    while (!instr_valid && n < 10) begin
      step();
      n++;
    end
    if (!instr_valid) chk("go_timeout", 32'd0, 32'd1);
    instr_ack = 1'b1;
    PCsrc     = src;
    ImmOp     = imm;
    step();
    instr_ack = 1'b0;
    PCsrc     = 1'b0;
    ImmOp     = '0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int k;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", PC, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);

    // zero-wait memory, ack held high
    release_reset();
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    imem_ready = 1'b1;
    instr_ack  = 1'b1;
    step();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("stream_req", {31'b0, imem_req}, {31'b0, i[0]});
      if (imem_req) begin
        k++;
        chk("stream_addr", imem_addr, 32'(4 * k));
      end
    end
    chk("stream_cnt", 32'(k), 32'd3);

    // branches
    go(1'b0, 32'h0);
    chk("seq_10", imem_addr, 32'h10);
    go(1'b1, 32'hFFFF_FFF8);
    chk("br_neg", imem_addr, 32'h08);
    go(1'b0, 32'h0);
    go(1'b0, 32'h0);
    chk("seq_back", imem_addr, 32'h10);
    go(1'b1, 32'h6);
    chk("br_mask", imem_addr, 32'h14);

    // memory wait of three cycles
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_req", {31'b0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'h14);
    end
    imem_ready = 1'b1;
    step();
    chk("wait_instr", instr, mem_word(32'h14, salt));

    // back-pressure with PCsrc toggling
    imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      PCsrc = ~PCsrc;
      ImmOp = $urandom;
      step();
      chk("bp_valid", {31'b0, instr_valid}, 32'd1);
      chk("bp_pc", PC, 32'h14);
    end
    PCsrc = 1'b0;
    go(1'b0, 32'h0);
    chk("bp_next", imem_addr, 32'h18);

    // wrap past the top of the address space
    go(1'b1, 32'hFFFF_FFE4);
    chk("to_top", imem_addr, 32'hFFFF_FFFC);
    go(1'b0, 32'h0);
    chk("wrap", imem_addr, 32'h0);

    // reset mid-fetch
    go(1'b1, 32'h40);
    imem_ready = 1'b0;
    chk("pre_rst_addr", imem_addr, 32'h40);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_req", {31'b0, imem_req}, 32'd0);
    chk("async_pc", PC, 32'h0);
    chk("async_instr", instr, 32'h0000_0013);
    chk("async_valid", {31'b0, instr_valid}, 32'd0);
    imem_ready = 1'b1;
    @(negedge clk);
    check_all();
    imem_ready = 1'b0;
    release_reset();
    step();
    chk("rst_refetch", imem_addr, 32'h0);

    // random handshakes
    salt = $urandom;
    for (int i = 0; i < 500; i++) begin
      imem_ready = ($urandom_range(0, 9) < 7);
      instr_ack  = ($urandom_range(0, 9) < 6);
      PCsrc      = $urandom_range(0, 1) == 1;
      ImmOp      = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
